// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl
//   Write-only sequencer for an HD44780 16x2 character LCD on an 8-bit bus.
//   After reset it idles for the power-up delay and then plays the init ROM.
//   After that it takes command/data bytes over a valid/ready handshake and
//   produces the RS/E/DB timing plus the post-write execution delay.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   in_valid   requester has a byte
//   in_ready   byte is accepted on an edge where in_valid & in_ready
//   in_rs      0 = command, 1 = character data
//   in_data    byte to write
//   init_done  init sequence finished (held until the next reset)
//   busy       ~in_ready
//   lcd_on     LCD power enable
//   lcd_blon   backlight enable
//   lcd_en     HD44780 E strobe
//   lcd_rw     always 0 (no busy-flag reads)
//   lcd_rs     HD44780 RS
//   lcd_data   HD44780 DB7..DB0
//
// state     | meaning
// ----------+------------------------------------------------------------
// PWRUP     | power-up delay after reset, counts up to PWRUP_CYC
// SETUP     | RS/DB driven, E low
// EN_HI     | E high
// HOLD      | E low again, RS/DB held
// WAIT      | LCD execution delay
// INIT_NEXT | step to the next init ROM entry
// IDLE      | ready for a requester byte
module lcd_hd44780_ctrl #(
  parameter int PWRUP_CYC    = 750000,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int EN_SETUP_CYC = 3,
  parameter int EN_HIGH_CYC  = 12,
  parameter int EN_HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_P = max2(max2(max2(PWRUP_CYC, CLR_WAIT_CYC), max2(CMD_WAIT_CYC, EN_SETUP_CYC)),
                              max2(EN_HIGH_CYC, EN_HOLD_CYC));
  localparam int CW = $clog2(MAX_P + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t PWRUP_LAST = cnt_t'(PWRUP_CYC - 1);
  localparam cnt_t SETUP_LAST = cnt_t'(EN_SETUP_CYC - 1);
  localparam cnt_t HIGH_LAST  = cnt_t'(EN_HIGH_CYC - 1);
  localparam cnt_t HOLD_LAST  = cnt_t'(EN_HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_INIT_NEXT, S_IDLE
  } state_t;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction

  state_t     state;
  cnt_t       cnt;
  logic [2:0] init_idx;

  // Clear (0x01) and home (0x02/0x03) need the long execution delay.
  logic slow_cmd;
  cnt_t wait_cyc;
  cnt_t wait_m2;
  logic wait_is_one;
  logic last_init;

  assign slow_cmd    = ~lcd_rs & ((lcd_data[7:1] == 7'b0000000) | (lcd_data[7:1] == 7'b0000001));
  assign wait_cyc    = slow_cmd ? cnt_t'(CLR_WAIT_CYC) : cnt_t'(CMD_WAIT_CYC);
  assign wait_m2     = wait_cyc - cnt_t'(2);
  assign wait_is_one = (wait_cyc == cnt_t'(1));
  assign last_init   = (init_idx == 3'd5);

  assign busy   = ~in_ready;
  assign lcd_rw = 1'b0;

  // The clock spent in INIT_NEXT or IDLE is the final clock of the wait, so
  // WAIT itself lasts one clock less than the wait count. This makes the
  // accept-to-next-accept period exactly setup+high+hold+wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_PWRUP;
      cnt       <= '0;
      init_idx  <= 3'd0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_on    <= 1'b0;
      lcd_blon  <= 1'b0;
      in_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      lcd_on   <= 1'b1;
      lcd_blon <= 1'b1;
      case (state)
        S_PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            state    <= S_SETUP;
            cnt      <= SETUP_LAST;
            lcd_rs   <= 1'b0;
            lcd_data <= init_rom(3'd0);
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state  <= S_EN_HI;
            cnt    <= HIGH_LAST;
            lcd_en <= 1'b1;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        S_EN_HI: begin
          if (cnt == '0) begin
            state  <= S_HOLD;
            cnt    <= HOLD_LAST;
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            if (wait_is_one) begin
              if (!init_done && !last_init) begin
                state <= S_INIT_NEXT;
              end else begin
                state     <= S_IDLE;
                in_ready  <= 1'b1;
                init_done <= 1'b1;
              end
            end else begin
              state <= S_WAIT;
              cnt   <= wait_m2;
            end
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (!init_done && !last_init) begin
              state <= S_INIT_NEXT;
            end else begin
              state     <= S_IDLE;
              in_ready  <= 1'b1;
              init_done <= 1'b1;
            end
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        S_INIT_NEXT: begin
          init_idx <= init_idx + 3'd1;
          lcd_rs   <= 1'b0;
          lcd_data <= init_rom(init_idx + 3'd1);
          state    <= S_SETUP;
          cnt      <= SETUP_LAST;
        end
        S_IDLE: begin
          if (in_valid && in_ready) begin
            lcd_rs   <= in_rs;
            lcd_data <= in_data;
            in_ready <= 1'b0;
            state    <= S_SETUP;
            cnt      <= SETUP_LAST;
          end
        end
        default: begin
          state <= S_PWRUP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
